// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB completer and its wait-state counter.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  localparam int DATA_W = 32;

  // True when a word index addresses an implemented register.
  function automatic logic idx_valid(input int idx, input int num_regs);
    return (idx < num_regs);
  endfunction

endpackage

// File: rtl/apb_completer_regs_if.sv
// APB3 bus bundle between an initiator (master) and the register completer (slave).
interface apb_completer_regs_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = 8
) ();

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_wait_counter.sv
// Wait-state counter: cleared on request, then counts up to WAIT_CYCLES and holds.
module apb_wait_counter
  import apb_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam logic [3:0] WAIT_L = 4'(WAIT_CYCLES);

  logic [3:0] cnt;

  assign done = (cnt == WAIT_L);

  // Count while enabled and not yet at the terminal value; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !done) begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/apb_completer_regs.sv
// APB3 completer with a small register file, fixed wait states, error response
// for illegal accesses and a sticky handshake-violation flag.
//
//   state  | meaning
//   IDLE   | no transfer; waiting for psel with penable low
//   SETUP  | setup phase sampled; address/direction latched
//   ACCESS | access phase; wait states counted, pready when done
module apb_completer_regs
  import apb_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter int                NUM_REGS    = 4,
  parameter int                WAIT_CYCLES = 2,
  parameter logic [DATA_W-1:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic                       clk,
  input  logic                       rst_n,
  apb_completer_regs_if.slave        bus,
  output logic [DATA_W*NUM_REGS-1:0] reg_q,
  output logic                       proto_err
);

  localparam int             IDX_W  = ADDR_W - 2;
  localparam logic [IDX_W-1:0] ID_IDX = IDX_W'(NUM_REGS - 1);

  apb_state_e        state;
  logic [IDX_W-1:0]  idx_q;
  logic              pwrite_q;
  logic [DATA_W-1:0] regs [NUM_REGS-1];

  logic [IDX_W-1:0]  idx_in;
  logic              wait_done;
  logic              in_range;
  logic              is_id;
  logic              err_resp;
  logic              access_viol;
  logic              ready;
  logic              wr_commit;
  logic [DATA_W-1:0] rdata;

  assign idx_in   = bus.paddr[ADDR_W-1:2];
  assign in_range = idx_valid(32'(idx_q), NUM_REGS);
  assign is_id    = (idx_q == ID_IDX);
  assign err_resp = !in_range || (pwrite_q && is_id);

  // Any of these seen during ACCESS ends the transfer without effect.
  assign access_viol = !bus.psel || !bus.penable ||
                       (idx_in != idx_q) || (bus.pwrite != pwrite_q);

  // pready depends only on FSM progress and the handshake, never on address/data.
  assign ready     = (state == ACCESS) && wait_done && bus.psel && bus.penable;
  assign wr_commit = ready && !access_viol && pwrite_q && in_range && !is_id;

  apb_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state == SETUP),
    .enable (state == ACCESS),
    .done   (wait_done)
  );

  // Transfer sequencing, address/direction latch and sticky violation flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx_q     <= '0;
      pwrite_q  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.psel && !bus.penable) begin
            state    <= SETUP;
            idx_q    <= idx_in;
            pwrite_q <= bus.pwrite;
          end else if (bus.psel && bus.penable) begin
            proto_err <= 1'b1;
          end
        end
        SETUP: begin
          if (!bus.psel) begin
            state     <= IDLE;
            proto_err <= 1'b1;
          end else begin
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (access_viol) begin
            state     <= IDLE;
            proto_err <= 1'b1;
          end else if (ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Writable registers; the ID slot is a constant and never stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        if (wr_commit && (idx_q == IDX_W'(i))) begin
          regs[i] <= bus.pwdata;
        end
      end
    end
  end

  // Read mux over the latched index.
  always_comb begin
    rdata = '0;
    if (is_id) begin
      rdata = ID_VALUE;
    end
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      if (idx_q == IDX_W'(i)) begin
        rdata = regs[i];
      end
    end
  end

  // Flattened register view, ID constant in the top slot.
  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      reg_q[DATA_W*i +: DATA_W] = regs[i];
    end
    reg_q[DATA_W*(NUM_REGS-1) +: DATA_W] = ID_VALUE;
  end

  assign bus.pready  = ready;
  assign bus.pslverr = ready && err_resp;
  assign bus.prdata  = (ready && !err_resp && !pwrite_q) ? rdata : '0;

endmodule

// File: tb/tb_apb_completer_regs.sv
// Bench for apb_completer_regs: a zero-wait instance (d=0) and a two-wait
// instance (d=1) driven independently, checked against a register-array model.
module tb_apb_completer_regs;

  localparam logic [31:0] ID = 32'hA5B0_0001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        psel_d    [2];
  logic        penable_d [2];
  logic        pwrite_d  [2];
  logic [7:0]  paddr_d   [2];
  logic [31:0] pwdata_d  [2];

  apb_completer_regs_if #(.ADDR_W(8)) bus0 ();
  apb_completer_regs_if #(.ADDR_W(8)) bus1 ();

  assign bus0.psel    = psel_d[0];
  assign bus0.penable = penable_d[0];
  assign bus0.pwrite  = pwrite_d[0];
  assign bus0.paddr   = paddr_d[0];
  assign bus0.pwdata  = pwdata_d[0];
  assign bus1.psel    = psel_d[1];
  assign bus1.penable = penable_d[1];
  assign bus1.pwrite  = pwrite_d[1];
  assign bus1.paddr   = paddr_d[1];
  assign bus1.pwdata  = pwdata_d[1];

  logic [127:0] regq0, regq1;
  logic         perr0, perr1;

  apb_completer_regs #(.ADDR_W(8), .NUM_REGS(4), .WAIT_CYCLES(0), .ID_VALUE(ID)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .reg_q(regq0), .proto_err(perr0));
  apb_completer_regs #(.ADDR_W(8), .NUM_REGS(4), .WAIT_CYCLES(2), .ID_VALUE(ID)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .reg_q(regq1), .proto_err(perr1));

  int checks = 0;
  int errors = 0;

  // Reference model: plain register array per instance plus sticky error flag.
  logic [31:0] mregs [2][3];
  bit          mperr [2];
  int          pulses [2];

  always @(negedge clk) begin
    if (bus0.pready) pulses[0]++;
    if (bus1.pready) pulses[1]++;
  end

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction
  function automatic logic get_rdy(input int d);
    return (d == 0) ? bus0.pready : bus1.pready;
  endfunction
  function automatic logic get_slverr(input int d);
    return (d == 0) ? bus0.pslverr : bus1.pslverr;
  endfunction
  function automatic logic [31:0] get_rdata(input int d);
    return (d == 0) ? bus0.prdata : bus1.prdata;
  endfunction
  function automatic logic [127:0] get_regq(input int d);
    return (d == 0) ? regq0 : regq1;
  endfunction
  function automatic logic get_perr(input int d);
    return (d == 0) ? perr0 : perr1;
  endfunction
  function automatic logic [127:0] exp_regq(input int d);
    return {ID, mregs[d][2], mregs[d][1], mregs[d][0]};
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 3; i++) mregs[d][i] = '0;
      mperr[d] = 1'b0;
    end
  endfunction

  // One legal transfer as the model sees it: 4 word slots, top one read-only ID.
  function automatic void model_xfer(input int d, input bit wr, input logic [7:0] addr,
                                     input logic [31:0] wd, output logic [31:0] rd, output bit err);
    int idx;
    idx = int'(addr) / 4;
    rd  = '0;
    err = 1'b0;
    if (idx >= 4) err = 1'b1;
    else if (idx == 3) begin
      if (wr) err = 1'b1;
      else rd = ID;
    end else if (wr) mregs[d][idx] = wd;
    else rd = mregs[d][idx];
  endfunction

  task automatic bus_idle(input int d);
    psel_d[d] = 1'b0;
    penable_d[d] = 1'b0;
  endtask

  // Drives one transfer starting just after an edge; returns observations only.
  // lat = completion edge counted from the edge that sampled the setup phase.
  task automatic xfer(input int d, input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                      output int lat, output logic [31:0] rd, output bit err, output bit tmo);
    psel_d[d] = 1'b1;
    penable_d[d] = 1'b0;
    pwrite_d[d] = wr;
    paddr_d[d] = addr;
    pwdata_d[d] = wd;
    @(posedge clk); #1;
    penable_d[d] = 1'b1;
    lat = 1;
    tmo = 1'b1;
    rd = '0;
    err = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (get_rdy(d)) begin
        rd = get_rdata(d);
        err = get_slverr(d);
        tmo = 1'b0;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    @(posedge clk); #1;
    bus_idle(d);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) bus_idle(d);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (get_rdy(d) !== 1'b0) begin errors++; $display("FAIL reset_pready d%0d: got %b want 0", d, get_rdy(d)); end
      checks++; if (get_slverr(d) !== 1'b0) begin errors++; $display("FAIL reset_pslverr d%0d: got %b want 0", d, get_slverr(d)); end
      checks++; if (get_rdata(d) !== 32'h0) begin errors++; $display("FAIL reset_prdata d%0d: got %h want 0", d, get_rdata(d)); end
      checks++; if (get_regq(d) !== exp_regq(d)) begin errors++; $display("FAIL reset_reg_q d%0d: got %h want %h", d, get_regq(d), exp_regq(d)); end
      checks++; if (get_perr(d) !== 1'b0) begin errors++; $display("FAIL reset_proto_err d%0d: got %b want 0", d, get_perr(d)); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_wait();
    int lat; logic [31:0] rd, erd; bit err, eerr, tmo;
    model_xfer(0, 1'b1, 8'h04, 32'hDEAD_BEEF, erd, eerr);
    xfer(0, 1'b1, 8'h04, 32'hDEAD_BEEF, lat, rd, err, tmo);
    checks++; if (tmo || lat != 2) begin errors++; $display("FAIL zw_write_latency: got %0d tmo=%b want 2", lat, tmo); end
    checks++; if (get_regq(0) !== exp_regq(0)) begin errors++; $display("FAIL zw_write_reg_q: got %h want %h", get_regq(0), exp_regq(0)); end
    model_xfer(0, 1'b0, 8'h04, 32'h0, erd, eerr);
    xfer(0, 1'b0, 8'h04, 32'h0, lat, rd, err, tmo);
    checks++; if (tmo || lat != 2) begin errors++; $display("FAIL zw_read_latency: got %0d tmo=%b want 2", lat, tmo); end
    checks++; if (rd !== erd || err !== eerr) begin errors++; $display("FAIL zw_read_data: got %h/%b want %h/%b", rd, err, erd, eerr); end
  endtask

  task automatic test_wait_states();
    int lat; logic [31:0] rd, erd; bit err, eerr, tmo;
    model_xfer(1, 1'b0, 8'h0C, 32'h0, erd, eerr);
    xfer(1, 1'b0, 8'h0C, 32'h0, lat, rd, err, tmo);
    checks++; if (tmo || lat != 4) begin errors++; $display("FAIL ws_latency: got %0d tmo=%b want 4", lat, tmo); end
    checks++; if (rd !== ID || err !== 1'b0) begin errors++; $display("FAIL ws_id_read: got %h/%b want %h/0", rd, err, ID); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd, erd; bit err, eerr, tmo;
    for (int d = 0; d < 2; d++) begin
      model_xfer(d, 1'b1, 8'h0C, 32'h1111_2222, erd, eerr);
      xfer(d, 1'b1, 8'h0C, 32'h1111_2222, lat, rd, err, tmo);
      checks++; if (tmo || err !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_id_write d%0d: got slverr=%b prdata=%h tmo=%b want 1/0", d, err, rd, tmo); end
      model_xfer(d, 1'b0, 8'h10, 32'h0, erd, eerr);
      xfer(d, 1'b0, 8'h10, 32'h0, lat, rd, err, tmo);
      checks++; if (tmo || err !== 1'b1 || rd !== 32'h0 || lat != wait_of(d) + 2) begin errors++; $display("FAIL err_oor_read d%0d: got slverr=%b prdata=%h lat=%0d want 1/0/%0d", d, err, rd, lat, wait_of(d) + 2); end
      checks++; if (get_regq(d) !== exp_regq(d)) begin errors++; $display("FAIL err_reg_q d%0d: got %h want %h", d, get_regq(d), exp_regq(d)); end
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd, erd, wd; bit err, eerr, tmo, wr; logic [7:0] addr;
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 25; n++) begin
        wr = 1'($urandom_range(0, 1));
        addr = 8'($urandom_range(0, 23));
        wd = $urandom;
        model_xfer(d, wr, addr, wd, erd, eerr);
        xfer(d, wr, addr, wd, lat, rd, err, tmo);
        checks++;
        if (tmo || lat != wait_of(d) + 2 || err !== eerr || (!wr && rd !== erd) ||
            get_regq(d) !== exp_regq(d) || get_perr(d) !== mperr[d]) begin
          errors++;
          $display("FAIL rand d%0d wr=%b addr=%h: lat=%0d tmo=%b slverr=%b prdata=%h reg_q=%h perr=%b want lat=%0d slverr=%b prdata=%h reg_q=%h perr=%b",
                   d, wr, addr, lat, tmo, err, rd, get_regq(d), get_perr(d), wait_of(d) + 2, eerr, erd, exp_regq(d), mperr[d]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, p0; logic [31:0] rd, erd; bit err, eerr, tmo1, tmo2;
    for (int d = 0; d < 2; d++) begin
      p0 = pulses[d];
      model_xfer(d, 1'b1, 8'h00, 32'h1, erd, eerr);
      model_xfer(d, 1'b1, 8'h08, 32'h2, erd, eerr);
      xfer(d, 1'b1, 8'h00, 32'h1, lat1, rd, err, tmo1);
      xfer(d, 1'b1, 8'h08, 32'h2, lat2, rd, err, tmo2);
      @(negedge clk);
      checks++; if (pulses[d] - p0 != 2) begin errors++; $display("FAIL b2b_pulses d%0d: got %0d want 2", d, pulses[d] - p0); end
      checks++; if (tmo1 || tmo2 || lat2 != wait_of(d) + 2) begin errors++; $display("FAIL b2b_latency d%0d: got %0d want %0d", d, lat2, wait_of(d) + 2); end
      checks++; if (get_regq(d) !== exp_regq(d)) begin errors++; $display("FAIL b2b_reg_q d%0d: got %h want %h", d, get_regq(d), exp_regq(d)); end
      checks++; if (get_perr(d) !== 1'b0) begin errors++; $display("FAIL b2b_proto_err d%0d: got %b want 0", d, get_perr(d)); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_abort();
    int lat, p0; logic [31:0] rd, erd; bit err, eerr, tmo;
    p0 = pulses[1];
    psel_d[1] = 1'b1; penable_d[1] = 1'b0; pwrite_d[1] = 1'b1;
    paddr_d[1] = 8'h00; pwdata_d[1] = 32'h1234;
    @(posedge clk); #1;
    penable_d[1] = 1'b1;
    @(posedge clk); #1;
    bus_idle(1);
    @(posedge clk);
    @(negedge clk);
    mperr[1] = 1'b1;
    checks++; if (get_regq(1) !== exp_regq(1)) begin errors++; $display("FAIL abort_reg_q: got %h want %h", get_regq(1), exp_regq(1)); end
    checks++; if (get_perr(1) !== 1'b1) begin errors++; $display("FAIL abort_proto_err: got %b want 1", get_perr(1)); end
    checks++; if (pulses[1] != p0) begin errors++; $display("FAIL abort_pready: got %0d pulses want 0", pulses[1] - p0); end
    @(posedge clk); #1;
    model_xfer(1, 1'b0, 8'h00, 32'h0, erd, eerr);
    xfer(1, 1'b0, 8'h00, 32'h0, lat, rd, err, tmo);
    checks++; if (tmo || lat != 4 || rd !== erd || err !== 1'b0) begin errors++; $display("FAIL abort_recover: got lat=%0d prdata=%h slverr=%b want 4/%h/0", lat, rd, err, erd); end
  endtask

  task automatic test_idle_violation();
    int lat; logic [31:0] rd, erd; bit err, eerr, tmo;
    psel_d[0] = 1'b1; penable_d[0] = 1'b1; pwrite_d[0] = 1'b1;
    paddr_d[0] = 8'h08; pwdata_d[0] = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    bus_idle(0);
    @(negedge clk);
    mperr[0] = 1'b1;
    checks++; if (get_perr(0) !== 1'b1) begin errors++; $display("FAIL idle_viol_proto_err: got %b want 1", get_perr(0)); end
    checks++; if (get_regq(0) !== exp_regq(0)) begin errors++; $display("FAIL idle_viol_reg_q: got %h want %h", get_regq(0), exp_regq(0)); end
    @(posedge clk); #1;
    model_xfer(0, 1'b1, 8'h08, 32'h55AA_55AA, erd, eerr);
    xfer(0, 1'b1, 8'h08, 32'h55AA_55AA, lat, rd, err, tmo);
    checks++; if (tmo || lat != 2 || get_regq(0) !== exp_regq(0)) begin errors++; $display("FAIL idle_viol_recover: got lat=%0d reg_q=%h want 2/%h", lat, get_regq(0), exp_regq(0)); end
  endtask

  task automatic test_reset_mid();
    psel_d[1] = 1'b1; penable_d[1] = 1'b0; pwrite_d[1] = 1'b1;
    paddr_d[1] = 8'h04; pwdata_d[1] = 32'hFFFF_0000;
    @(posedge clk); #1;
    penable_d[1] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (get_rdy(1) !== 1'b0) begin errors++; $display("FAIL rst_mid_pready: got %b want 0", get_rdy(1)); end
    checks++; if (get_perr(1) !== 1'b0 || get_perr(0) !== 1'b0) begin errors++; $display("FAIL rst_mid_proto_err: got %b%b want 00", get_perr(1), get_perr(0)); end
    bus_idle(1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (get_regq(1) !== exp_regq(1) || get_regq(0) !== exp_regq(0)) begin errors++; $display("FAIL rst_mid_reg_q: got %h/%h want %h", get_regq(0), get_regq(1), exp_regq(1)); end
    @(posedge clk); #1;
  endtask

  task automatic test_addr_change();
    int lat, p0; logic [31:0] rd, erd; bit err, eerr, tmo;
    p0 = pulses[1];
    psel_d[1] = 1'b1; penable_d[1] = 1'b0; pwrite_d[1] = 1'b1;
    paddr_d[1] = 8'h00; pwdata_d[1] = 32'h77;
    @(posedge clk); #1;
    penable_d[1] = 1'b1;
    @(posedge clk); #1;
    paddr_d[1] = 8'h04;
    @(posedge clk); #1;
    bus_idle(1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    mperr[1] = 1'b1;
    checks++; if (get_perr(1) !== 1'b1) begin errors++; $display("FAIL addr_chg_proto_err: got %b want 1", get_perr(1)); end
    checks++; if (get_regq(1) !== exp_regq(1) || pulses[1] != p0) begin errors++; $display("FAIL addr_chg_no_xfer: got reg_q=%h pulses=%0d want %h/0", get_regq(1), pulses[1] - p0, exp_regq(1)); end
    @(posedge clk); #1;
    model_xfer(1, 1'b0, 8'h00, 32'h0, erd, eerr);
    xfer(1, 1'b0, 8'h00, 32'h0, lat, rd, err, tmo);
    checks++; if (tmo || lat != 4 || rd !== erd) begin errors++; $display("FAIL addr_chg_recover: got lat=%0d prdata=%h want 4/%h", lat, rd, erd); end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      bus_idle(d);
      pwrite_d[d] = 1'b0;
      paddr_d[d] = '0;
      pwdata_d[d] = '0;
      pulses[d] = 0;
    end
    model_reset();
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_errors();
    test_random();
    test_back_to_back();
    test_abort();
    test_idle_violation();
    test_reset_mid();
    test_addr_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
